// File: rtl/mem_access_controller_if.sv
// Data-memory bus between the access controller and the memory.
// The controller drives the request side; the memory returns MemAck/MemRData.
interface mem_access_controller_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  MemReq;
  logic                  MemWe;
  logic [3:0]            MemByteEn;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic [31:0]           MemWData;
  logic                  MemAck;
  logic [31:0]           MemRData;

  modport master (
    output MemReq, MemWe, MemByteEn, MemAddr, MemWData,
    input  MemAck, MemRData
  );

  modport slave (
    input  MemReq, MemWe, MemByteEn, MemAddr, MemWData,
    output MemAck, MemRData
  );
endinterface

// File: rtl/mem_access_controller.sv
// MEM-stage access sequencer: req/ack data memory, stall, align, extend.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_controller #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [1:0]              MemReadIn,
  input  logic [1:0]              MemWriteIn,
  input  logic                    SignedLoadIn,
  input  logic [ADDR_WIDTH-1:0]   AddressIn,
  input  logic [31:0]             WriteDataIn,
  mem_access_controller_if.master mem,
  output logic [31:0]             ReadDataOut,
  output logic                    Stall,
  output logic                    Misaligned,
  output logic                    BusError
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state;
  logic                  req_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wd_q;
  logic [1:0]            size_q;
  logic [1:0]            lane_q;
  logic                  sgn_q;

  logic       is_wr;
  logic       acc;
  logic [1:0] sz;
  logic [1:0] lane;
  logic       aligned;
  logic [3:0] be;
  logic [31:0] wd;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ld;

  assign is_wr = |MemWriteIn;
  assign acc   = is_wr | (|MemReadIn);
  assign sz    = is_wr ? MemWriteIn : MemReadIn;
  assign lane  = AddressIn[1:0];

  // size decode: alignment, lane enables, replicated store data
  always_comb begin
    aligned = 1'b1;
    be      = 4'b0000;
    wd      = WriteDataIn;
    unique case (sz)
      2'b01: begin
        be = 4'b0001 << lane;
        wd = {4{WriteDataIn[7:0]}};
      end
      2'b10: begin
        aligned = ~AddressIn[0];
        be      = 4'b0011 << lane;
        wd      = {2{WriteDataIn[15:0]}};
      end
      2'b11: begin
        aligned = (lane == 2'b00);
        be      = 4'b1111;
      end
      default: ;
    endcase
  end

  // load extract at the latched lane, sign/zero extend
  always_comb begin
    bsel = mem.MemRData[8*lane_q +: 8];
    hsel = lane_q[1] ? mem.MemRData[31:16] : mem.MemRData[15:0];
    ld   = mem.MemRData;
    unique case (size_q)
      2'b01:   ld = {{24{sgn_q & bsel[7]}}, bsel};
      2'b10:   ld = {{16{sgn_q & hsel[15]}}, hsel};
      default: ld = mem.MemRData;
    endcase
  end

  assign Stall = (state == S_REQ) ||
                 ((state == S_IDLE) && acc && aligned);

  assign mem.MemReq    = req_q;
  assign mem.MemWe     = we_q;
  assign mem.MemByteEn = be_q;
  assign mem.MemAddr   = addr_q;
  assign mem.MemWData  = wd_q;

`ifdef MEM_TIMEOUT_EN
  localparam int CW =
    ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign BusError = 1'b0;
`endif

  // access FSM with registered bus and status outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'b0000;
      addr_q      <= '0;
      wd_q        <= '0;
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      sgn_q       <= 1'b0;
      ReadDataOut <= '0;
      Misaligned  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt         <= '0;
      BusError    <= 1'b0;
`endif
    end else begin
      Misaligned <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      BusError   <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (acc && aligned) begin
            req_q  <= 1'b1;
            we_q   <= is_wr;
            be_q   <= be;
            addr_q <= {AddressIn[ADDR_WIDTH-1:2], 2'b00};
            wd_q   <= wd;
            size_q <= sz;
            lane_q <= lane;
            sgn_q  <= SignedLoadIn;
`ifdef MEM_TIMEOUT_EN
            cnt    <= '0;
`endif
            state  <= S_REQ;
          end else if (acc) begin
            Misaligned <= 1'b1;
          end
        end
        S_REQ: begin
          if (mem.MemAck) begin
            req_q <= 1'b0;
            if (!we_q) ReadDataOut <= ld;
            state <= S_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt == LIM) begin
            req_q    <= 1'b0;
            BusError <= 1'b1;
            if (!we_q) ReadDataOut <= '0;
            state    <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Sequences every data-memory access issued from the EX/MEM pipeline register against a variable-latency data memory with a req/ack handshake.
- Decodes the 2-bit MemRead/MemWrite size codes into byte enables and lane-aligned write data, and extracts and extends load data.
- Asserts Stall to freeze the PC, IF/ID, ID/EX and EX/MEM registers until the access completes.
- Sits between the EX/MEM register outputs and the MEM/WB register inputs.

Parameters:
- ADDR_WIDTH, 32, width of the memory address bus.
- TIMEOUT_CYCLES, 64, cycles in REQ without MemAck before the access is aborted (used only with MEM_TIMEOUT_EN).

Ports:
- Clock  input  1  pipeline clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- MemReadIn  input  2  load size from EX/MEM: 00 none, 01 byte, 10 half, 11 word.
- MemWriteIn  input  2  store size, same encoding as MemReadIn.
- SignedLoadIn  input  1  1 = sign-extend byte/half loads, 0 = zero-extend.
- AddressIn  input  ADDR_WIDTH  effective address (ALU result).
- WriteDataIn  input  32  store data (ReadData2), right-justified.
- MemReq  output  1  request to data memory.
- MemWe  output  1  1 = write, 0 = read; valid while MemReq=1.
- MemByteEn  output  4  byte lane enables; valid while MemReq=1.
- MemAddr  output  ADDR_WIDTH  word-aligned address ({AddressIn[ADDR_WIDTH-1:2],2'b00}).
- MemWData  output  32  lane-replicated store data.
- MemAck  input  1  memory completion; single-cycle pulse.
- MemRData  input  32  read word; valid when MemAck=1.
- ReadDataOut  output  32  extended load result to MEM/WB.
- Stall  output  1  freeze upstream pipeline registers.
- Misaligned  output  1  one-cycle pulse on an alignment fault.
- BusError  output  1  one-cycle pulse on timeout (only with MEM_TIMEOUT_EN; tied 0 without it).

Behaviour:
- Reset (synchronous): state=IDLE; MemReq=0, MemWe=0, MemByteEn=0, MemAddr=0, MemWData=0, ReadDataOut=0, Misaligned=0, BusError=0, timeout counter=0. Reset asserted in any state, including REQ with an outstanding request, drops MemReq on the next edge; any later MemAck is ignored.
- Access detect: access = (MemReadIn!=0) | (MemWriteIn!=0). If both are nonzero, the write takes priority and the read is ignored.
- Alignment:
  - half requires AddressIn[0]=0; word requires AddressIn[1:0]=0.
  - A misaligned access issues no request and keeps Stall=0.
  - It pulses Misaligned for 1 cycle (registered) and leaves ReadDataOut unchanged.
- States:
  - IDLE: Stall = access & aligned (combinational). On an aligned access, register MemAddr, MemWe, MemByteEn and MemWData, then go to REQ.
  - REQ: MemReq=1, Stall=1. Outputs are held stable until MemAck. On MemAck, register ReadDataOut (for reads), drop MemReq and go to DONE. MemAck may arrive in the first REQ cycle.
  - DONE: Stall=0, MemReq=0. The pipeline advances at this edge; go to IDLE unconditionally. The DONE cycle is never treated as a new access, so the same access cannot re-trigger.
- Latency: with MemAck in the first REQ cycle, Stall is high for 2 cycles and ReadDataOut is valid in DONE. Each extra wait cycle adds 1 stall cycle.
- Byte enables (little-endian, lane = AddressIn[1:0]):
  - byte: 4'b0001<<lane.
  - half: 4'b0011<<lane.
  - word: 4'b1111.
- MemWData replicates the data across lanes: byte {4{WriteDataIn[7:0]}}, half {2{WriteDataIn[15:0]}}, word WriteDataIn.
- Load extract: select the byte or half at the lane offset, then sign- or zero-extend to 32 bits per SignedLoadIn; word loads pass through.
- MemAck while not in REQ: ignored.
- Writes leave ReadDataOut unchanged.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit or wider counter clears on entry to REQ and increments each REQ cycle without MemAck.
  - When it reaches TIMEOUT_CYCLES-1 with no ack: drop MemReq, pulse BusError for 1 cycle, set ReadDataOut=0 for reads, and go to DONE.
  - MemAck in that same cycle wins (normal completion, no BusError).
- MEM_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; BusError is constant 0.

Test Plan:
- Word load, AddressIn=0x100, MemAck in 1st REQ cycle, MemRData=0xDEADBEEF -> MemAddr=0x100, MemByteEn=1111, Stall high exactly 2 cycles, ReadDataOut=0xDEADBEEF in DONE.
- Signed byte load, AddressIn=0x103, MemRData=0x80112233, ack after 3 wait cycles -> MemByteEn=1000, Stall high 5 cycles, ReadDataOut=0xFFFFFF80. Repeat with SignedLoadIn=0 -> 0x00000080.
- Half store, AddressIn=0x202, WriteDataIn=0x0000ABCD -> MemWe=1, MemByteEn=1100, MemWData=0xABCDABCD, MemAddr=0x200.
- Misaligned word load, AddressIn=0x101 -> MemReq never asserted, Stall=0, Misaligned pulses 1 cycle. With MemRead=01 and MemWrite=11 at 0x104 -> write issued with MemByteEn=1111.
- Reset asserted during REQ, then MemAck pulses 2 cycles later -> all outputs return to reset values on the next edge, state IDLE, the ack has no effect.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> MemReq high 4 cycles, then BusError pulse, ReadDataOut=0, Stall releases in DONE.
